token_stream_rom: RTL and testbench

TOKEN_STREAM_ROM -- requirements
Module: token_stream_rom

---
 rtl/token_stream_rom.sv | 152 +++++++++++++++
 tb/tb_token_stream_rom.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/token_stream_rom.sv
// token_stream_rom: loadable token memory streamed out over a valid/ready port.
// A stream begins at start_addr and ends on the terminator token (TERM) or on
// the last entry. Ending on the last entry without a terminator raises err.
// Optional build macro TOKEN_ROM_PRELOAD_EN: reset also loads a fixed
// seven-token program into entries 0..6.
module token_stream_rom #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 100,
    parameter int ADDR_W = 7,
    parameter int TERM   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              tok_valid,
    input  logic              tok_ready,
    output logic [WIDTH-1:0]  tok_data,
    output logic              tok_last,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [WIDTH-1:0]  TERM_C   = WIDTH'(TERM);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  tok_data_q, tok_data_d;
    logic              err_q, err_d;
    logic              err_pulse_q, err_pulse_d;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic start_ok;
    logic start_bad;
    logic last_cond;
    logic xfer;
    logic mem_we;

    // Decoded conditions shared by the next-state and datapath logic
    always_comb begin
        start_ok  = start && ({1'b0, start_addr} < DEPTH_C);
        start_bad = start && ({1'b0, start_addr} >= DEPTH_C);
        last_cond = (tok_data_q == TERM_C) || (ptr_q == LAST_PTR);
        xfer      = (state_q == PRESENT) && tok_ready;
        // Loads only between streams so a running stream sees frozen contents
        mem_we    = rst && wr_en && ({1'b0, wr_addr} < DEPTH_C)
                    && ((state_q == IDLE) || (state_q == DONE));
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            tok_data_q  <= '0;
            err_q       <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            tok_data_q  <= tok_data_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = FETCH;
            FETCH:   state_d = PRESENT;
            PRESENT: if (xfer) state_d = last_cond ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pointer, registered memory read and error tracking
    always_comb begin
        ptr_d       = ptr_q;
        tok_data_d  = tok_data_q;
        err_d       = err_q;
        err_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Any start clears a stale error; a bad address raises a one-cycle pulse
                    err_d       = start_bad;
                    err_pulse_d = start_bad;
                    if (start_ok) ptr_d = start_addr;
                end else if (err_pulse_q) begin
                    err_d = 1'b0;
                end
            end
            FETCH: begin
                tok_data_d = mem[ptr_q];
            end
            PRESENT: begin
                if (xfer) begin
                    if (last_cond) err_d = (tok_data_q != TERM_C);
                    else           ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        tok_valid = (state_q == PRESENT);
        tok_last  = (state_q == PRESENT) && last_cond;
        tok_data  = tok_data_q;
        busy      = (state_q == FETCH) || (state_q == PRESENT);
        err       = err_q;
    end

    // Token storage; reset never clears it apart from the optional preload
    always_ff @(posedge clk) begin
`ifdef TOKEN_ROM_PRELOAD_EN
        if (!rst) begin
            mem[0] <= WIDTH'(2);
            mem[1] <= WIDTH'(0);
            mem[2] <= WIDTH'(23);
            mem[3] <= WIDTH'(2);
            mem[4] <= WIDTH'(20);
            mem[5] <= WIDTH'(2);
            mem[6] <= TERM_C;
        end else if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
`else
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_token_stream_rom.sv
// Directed testbench for token_stream_rom (default parameters).
module tb_token_stream_rom;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic [6:0] start_addr = '0;
    logic       tok_valid;
    logic       tok_ready = 1'b0;
    logic [7:0] tok_data;
    logic       tok_last;
    logic       busy;
    logic       err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_tok [8];

    token_stream_rom dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .start_addr (start_addr),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_data   (tok_data),
        .tok_last   (tok_last),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, obs);
        end
    endtask

    task automatic write_word(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Runs one stream from addr and checks n tokens against exp_tok.
    // toggle: stall every token for one cycle. inject: while busy, keep
    // writing 8'hEE at the pointer and issuing start to 40.
    // with_wr: write (wa, wd) in the same cycle as start.
    task automatic do_stream(input string name, input logic [6:0] addr, input bit toggle,
                             input bit inject, input bit with_wr, input logic [6:0] wa,
                             input logic [7:0] wd, input int n, input logic exp_err);
        int got = 0;
        int cyc = 0;
        bit stalled = 0;
        bit ready_ph = 0;
        logic [7:0] held = '0;
        @(negedge clk);
        start = 1'b1; start_addr = addr;
        if (with_wr) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        check({name, " busy_after_start"}, 32'(busy), 32'd1);
        while (got < n && cyc < 200) begin
            if (tok_valid) begin
                if (stalled) check({name, " held_data"}, 32'(tok_data), 32'(held));
                tok_ready = toggle ? ready_ph : 1'b1;
                ready_ph = !ready_ph;
                if (tok_ready) begin
                    check($sformatf("%s tok%0d", name, got), 32'(tok_data), 32'(exp_tok[got]));
                    check($sformatf("%s last%0d", name, got), 32'(tok_last), 32'(got == n - 1));
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = tok_data;
                end
            end else begin
                tok_ready = 1'b0;
            end
            if (inject) begin
                start = 1'b1; start_addr = 7'd40;
                wr_en = 1'b1; wr_data = 8'hEE;
                wr_addr = addr + 7'(got) + (tok_valid ? 7'd1 : 7'd0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; wr_en = 1'b0; tok_ready = 1'b0;
        check({name, " token_count"}, 32'(got), 32'(n));
        check({name, " done_valid"}, 32'(tok_valid), 32'd0);
        check({name, " done_busy"}, 32'(busy), 32'd0);
        check({name, " done_err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        check({name, " idle_err_held"}, 32'(err), 32'(exp_err));
    endtask

    task automatic set_prog;
        exp_tok[0] = 8'd2;  exp_tok[1] = 8'd0; exp_tok[2] = 8'd23; exp_tok[3] = 8'd2;
        exp_tok[4] = 8'd20; exp_tok[5] = 8'd2; exp_tok[6] = 8'd10;
    endtask

    initial begin
        int cyc;
        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst tok_valid", 32'(tok_valid), 32'd0);
        check("rst tok_last", 32'(tok_last), 32'd0);
        check("rst tok_data", 32'(tok_data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst err", 32'(err), 32'd0);
        rst = 1'b1;

        // Seven-token program at 0..6, streamed with ready held high
`ifndef TOKEN_ROM_PRELOAD_EN
        write_word(7'd0, 8'd2);  write_word(7'd1, 8'd0);  write_word(7'd2, 8'd23);
        write_word(7'd3, 8'd2);  write_word(7'd4, 8'd20); write_word(7'd5, 8'd2);
        write_word(7'd6, 8'd10);
`endif
        set_prog();
        do_stream("prog", 7'd0, 0, 0, 0, 7'd0, 8'd0, 7, 1'b0);

        // 5,7,TERM at 40..42 with a stalling consumer
        write_word(7'd40, 8'd5); write_word(7'd41, 8'd7); write_word(7'd42, 8'd10);
        exp_tok[0] = 8'd5; exp_tok[1] = 8'd7; exp_tok[2] = 8'd10;
        do_stream("stall", 7'd40, 1, 0, 0, 7'd0, 8'd0, 3, 1'b0);

        // No terminator up to the last entry
        write_word(7'd97, 8'd1); write_word(7'd98, 8'd2); write_word(7'd99, 8'd3);
        exp_tok[0] = 8'd1; exp_tok[1] = 8'd2; exp_tok[2] = 8'd3;
        do_stream("endmem", 7'd97, 0, 0, 0, 7'd0, 8'd0, 3, 1'b1);

        // Reset while a token waits in PRESENT
        @(negedge clk);
        start = 1'b1; start_addr = 7'd40;
        @(negedge clk);
        start = 1'b0; tok_ready = 1'b0;
        cyc = 0;
        while (!tok_valid && cyc < 20) begin @(negedge clk); cyc++; end
        check("rstmid valid_before", 32'(tok_valid), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstmid tok_valid", 32'(tok_valid), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rstmid no_more_tokens", 32'(tok_valid), 32'd0);
        exp_tok[0] = 8'd5; exp_tok[1] = 8'd7; exp_tok[2] = 8'd10;
        do_stream("after_rst", 7'd40, 0, 0, 0, 7'd0, 8'd0, 3, 1'b0);

        // Writes and starts while busy are ignored, then contents rechecked
        set_prog();
        do_stream("busy_inj", 7'd0, 1, 1, 0, 7'd0, 8'd0, 7, 1'b0);
        do_stream("recheck", 7'd0, 0, 0, 0, 7'd0, 8'd0, 7, 1'b0);

        // Write and start in the same cycle: stream sees new data
        exp_tok[0] = 8'd33; exp_tok[1] = 8'd7; exp_tok[2] = 8'd10;
        do_stream("wr_start", 7'd40, 0, 0, 1, 7'd40, 8'd33, 3, 1'b0);

        // start_addr == DEPTH: one-cycle error pulse, no stream
        @(negedge clk);
        start = 1'b1; start_addr = 7'd100;
        @(negedge clk);
        start = 1'b0;
        check("badaddr err_pulse", 32'(err), 32'd1);
        check("badaddr busy", 32'(busy), 32'd0);
        check("badaddr tok_valid", 32'(tok_valid), 32'd0);
        @(negedge clk);
        check("badaddr err_clear", 32'(err), 32'd0);
        check("badaddr busy2", 32'(busy), 32'd0);
        check("badaddr tok_valid2", 32'(tok_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
